// File: rtl/evm_pkg.sv
// Shared types and helpers for the EVM ballot-unit sequencer.
package evm_pkg;

  localparam int NUM_CAND_DEF = 5;
  // NOTA is always the most significant choice bit.
  localparam int NOTA_IDX = NUM_CAND_DEF - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_RELEASE = 3'd3,
    ST_CLOSED  = 3'd4
  } state_e;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/evm_edge_det.sv
// Rising-edge detector: registers the previous level and flags a 0->1 change.
module evm_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = sig;
    rise   = sig & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= prev_d;
  end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Ballot-unit sequencer: arm, single-choice capture, confirm hold, release lockout, poll close.
// Optional macro BALLOT_TIMEOUT_EN voids an armed ballot after TIMEOUT_CYC idle cycles.
module evm_ballot_ctrl
  import evm_pkg::*;
#(
  parameter int NUM_CAND    = NUM_CAND_DEF,
  parameter int CONF_CYC    = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ballot_issue,
  input  logic                poll_close,
  input  logic [NUM_CAND-1:0] vo_switch,
  output logic                vote_valid,
  output logic [NUM_CAND-1:0] vote_sel,
  output logic                ready_led,
  output logic [NUM_CAND-1:0] pled,
  output logic                invalid,
  output logic                timeout,
  output logic                closed,
  output logic [CNT_W-1:0]    cast_cnt
);

  localparam int MAX_CYC = (CONF_CYC > TIMEOUT_CYC) ? CONF_CYC : TIMEOUT_CYC;
  localparam int TIMER_W = $clog2(MAX_CYC) + 1;

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_ARMED   = ST_ARMED;
  localparam logic [2:0] S_CONFIRM = ST_CONFIRM;
  localparam logic [2:0] S_RELEASE = ST_RELEASE;
  localparam logic [2:0] S_CLOSED  = ST_CLOSED;

  logic [2:0]          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                cp_q, cp_d;
  logic                vv_q, vv_d;
  logic [NUM_CAND-1:0] sel_q, sel_d;
  logic [NUM_CAND-1:0] pled_q, pled_d;
  logic                inv_q, inv_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                issue_rise;
  logic                sw_onehot;
  logic                sw_multi;

  evm_edge_det u_issue_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (ballot_issue),
    .rise (issue_rise)
  );

  assign sw_onehot = is_onehot(32'(vo_switch));
  assign sw_multi  = (vo_switch != '0) && !sw_onehot;

`ifdef BALLOT_TIMEOUT_EN
  logic to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cp_d    = cp_q;
    vv_d    = 1'b0;
    sel_d   = '0;
    pled_d  = pled_q;
    inv_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef BALLOT_TIMEOUT_EN
    to_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        // A pending or live close beats a simultaneous ballot_issue edge.
        if (cp_q || poll_close) begin
          state_d = S_CLOSED;
        end else if (issue_rise) begin
          if (vo_switch == '0) state_d = S_ARMED;
          else                 inv_d   = 1'b1;
        end
      end
      S_ARMED: begin
        if (poll_close) cp_d = 1'b1;
        if (sw_onehot) begin
          vv_d    = 1'b1;
          sel_d   = vo_switch;
          pled_d  = vo_switch;
          timer_d = '0;
          state_d = S_CONFIRM;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          inv_d = sw_multi;
`ifdef BALLOT_TIMEOUT_EN
          if (timer_q == TIMER_W'(TIMEOUT_CYC - 1)) begin
            to_d    = 1'b1;
            timer_d = '0;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
`else
          if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
`endif
        end
      end
      S_CONFIRM: begin
        if (poll_close) cp_d = 1'b1;
        if (timer_q == TIMER_W'(CONF_CYC - 1)) begin
          pled_d  = '0;
          timer_d = '0;
          state_d = S_RELEASE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_RELEASE: begin
        if (poll_close) cp_d = 1'b1;
        // Lockout until every button is released, so a held key cannot vote twice.
        if (vo_switch == '0) state_d = S_IDLE;
      end
      S_CLOSED: state_d = S_CLOSED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cp_q    <= 1'b0;
      vv_q    <= 1'b0;
      sel_q   <= '0;
      pled_q  <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef BALLOT_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cp_q    <= cp_d;
      vv_q    <= vv_d;
      sel_q   <= sel_d;
      pled_q  <= pled_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
`ifdef BALLOT_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign vote_valid = vv_q;
  assign vote_sel   = sel_q;
  assign pled       = pled_q;
  assign invalid    = inv_q;
  assign cast_cnt   = cnt_q;
  assign ready_led  = (state_q == S_ARMED);
  assign closed     = (state_q == S_CLOSED);
`ifdef BALLOT_TIMEOUT_EN
  assign timeout    = to_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Bench for evm_ballot_ctrl: directed scenarios plus random traffic against a ballot-level model.
module tb_evm_ballot_ctrl;
  import evm_pkg::*;

  localparam int NC       = NUM_CAND_DEF;
  localparam int CONF     = 4;
  localparam int TMO      = 16;
  localparam int CW       = 8;
  localparam int CNT_MAX  = (1 << CW) - 1;
`ifdef BALLOT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          ballot_issue;
  logic          poll_close;
  logic [NC-1:0] vo_switch;
  logic          vote_valid;
  logic [NC-1:0] vote_sel;
  logic          ready_led;
  logic [NC-1:0] pled;
  logic          invalid;
  logic          timeout;
  logic          closed;
  logic [CW-1:0] cast_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  evm_ballot_ctrl #(
    .NUM_CAND(NC), .CONF_CYC(CONF), .TIMEOUT_CYC(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .ballot_issue(ballot_issue), .poll_close(poll_close),
    .vo_switch(vo_switch), .vote_valid(vote_valid), .vote_sel(vote_sel),
    .ready_led(ready_led), .pled(pled), .invalid(invalid), .timeout(timeout),
    .closed(closed), .cast_cnt(cast_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a ballot is armed, being confirmed (hold count),
  // awaiting key release, or the poll is over.
  bit          m_armed, m_release, m_closed, m_close_req, m_prev;
  int          m_hold, m_wait, m_cnt;
  logic [NC-1:0] m_pled, e_sel;
  bit          e_vv, e_inv, e_to;

  task automatic model_step();
    bit rise;
    e_vv = 0; e_inv = 0; e_to = 0; e_sel = '0;
    if (!rst) begin
      m_armed = 0; m_release = 0; m_closed = 0; m_close_req = 0; m_prev = 0;
      m_hold = 0; m_wait = 0; m_cnt = 0; m_pled = '0;
      return;
    end
    rise   = ballot_issue && !m_prev;
    m_prev = ballot_issue;
    if (m_closed) begin
      // poll over: nothing reacts
    end else if (m_armed) begin
      if (poll_close) m_close_req = 1;
      if ($countones(vo_switch) == 1) begin
        e_vv = 1; e_sel = vo_switch; m_pled = vo_switch;
        if (m_cnt < CNT_MAX) m_cnt++;
        m_hold = CONF; m_armed = 0;
      end else begin
        if ($countones(vo_switch) > 1) e_inv = 1;
        m_wait++;
        if (TO_EN && m_wait == TMO) begin
          e_to = 1; m_armed = 0;
        end
      end
    end else if (m_hold > 0) begin
      if (poll_close) m_close_req = 1;
      m_hold--;
      if (m_hold == 0) begin
        m_pled = '0; m_release = 1;
      end
    end else if (m_release) begin
      if (poll_close) m_close_req = 1;
      if (vo_switch == '0) m_release = 0;
    end else begin
      if (m_close_req || poll_close) m_closed = 1;
      else if (rise) begin
        if (vo_switch == '0) begin
          m_armed = 1; m_wait = 0;
        end else e_inv = 1;
      end
    end
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("vote_valid", 32'(vote_valid), 32'(e_vv));
    chk("vote_sel",   32'(vote_sel),   32'(e_sel));
    chk("ready_led",  32'(ready_led),  32'(m_armed));
    chk("pled",       32'(pled),       32'(m_pled));
    chk("invalid",    32'(invalid),    32'(e_inv));
    chk("timeout",    32'(timeout),    32'(e_to));
    chk("closed",     32'(closed),     32'(m_closed));
    chk("cast_cnt",   32'(cast_cnt),   32'(m_cnt));
  endtask

  // driver: advance one clock, update the model, sample away from the edge
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic arm();
    ballot_issue = 1'b1; tick();
    ballot_issue = 1'b0;
  endtask

  initial begin
    logic [NC-1:0] nota;
    nota = '0;
    nota[NOTA_IDX] = 1'b1;
    rst = 1'b0; ballot_issue = 1'b0; poll_close = 1'b0; vo_switch = '0;
    ticks(2);
    chk("reset_cnt", 32'(cast_cnt), 32'd0);
    rst = 1'b1; tick();

    // single valid vote
    arm(); tick();
    chk("armed_led", 32'(ready_led), 32'd1);
    vo_switch = 5'b00100; tick();
    chk("vote_sel_00100", 32'(vote_sel), 32'h04);
    vo_switch = '0; ticks(6);
    chk("cnt_after_first", 32'(cast_cnt), 32'd1);

    // multi-press rejected, then NOTA
    arm(); vo_switch = 5'b00110; tick();
    vo_switch = '0; tick();
    vo_switch = nota; tick();
    chk("vote_sel_nota", 32'(vote_sel), 32'h10);
    vo_switch = '0; ticks(6);

    // held key blocks re-arming until released
    arm(); tick();
    vo_switch = 5'b00001; tick();
    ticks(CONF);
    ballot_issue = 1'b1; tick();
    ballot_issue = 1'b0; ticks(3);
    chk("held_no_arm", 32'(ready_led), 32'd0);
    vo_switch = '0; ticks(2);
    chk("cnt_after_held", 32'(cast_cnt), 32'd3);

    // armed with no press
    arm(); ticks(TMO + 4);
    if (m_armed) begin
      vo_switch = 5'b00010; tick();
      vo_switch = '0; ticks(6);
    end

    // reset while armed with a press present
    arm(); tick();
    vo_switch = 5'b01000; rst = 1'b0; tick();
    chk("rst_mid_cnt", 32'(cast_cnt), 32'd0);
    rst = 1'b1; vo_switch = '0; ticks(2);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) ballot_issue = ~ballot_issue;
      if (r < 5)      vo_switch = '0;
      else if (r < 8) vo_switch = NC'(1) << $urandom_range(0, NC - 1);
      else            vo_switch = NC'($urandom_range(0, (1 << NC) - 1));
      poll_close = ($urandom_range(0, 399) == 0);
      rst        = ($urandom_range(0, 249) != 0);
      tick();
    end

    // close requested mid-ballot: vote still counts, poll closes afterwards
    rst = 1'b0; poll_close = 1'b0; ballot_issue = 1'b0; vo_switch = '0; tick();
    rst = 1'b1; tick();
    arm(); tick();
    vo_switch = 5'b00010; tick();
    vo_switch = '0; tick();
    poll_close = 1'b1; tick();
    poll_close = 1'b0; ticks(8);
    chk("closed_after", 32'(closed), 32'd1);
    chk("closed_cnt", 32'(cast_cnt), 32'd1);
    for (int i = 0; i < 12; i++) begin
      ballot_issue = i[0];
      vo_switch = NC'($urandom_range(0, (1 << NC) - 1));
      tick();
    end
    chk("closed_stays", 32'(closed), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/evm_ballot_ctrl.md
Name: evm_ballot_ctrl

Overview:
Ballot-unit sequencer in front of the EVM tally datapath. Sequences each vote through presiding-officer arming, single-choice capture, confirmation hold and switch-release lockout, and closes the poll. It emits exactly one registered one-hot vote pulse per issued ballot, which feeds the tally's enable and switch inputs.

Parameters:
NUM_CAND, 5, number of choices including NOTA (the MSB of vo_switch is NOTA)
CONF_CYC, 4, cycles the confirmation LED is held after a vote
TIMEOUT_CYC, 16, cycles an armed ballot waits before it is voided
CNT_W, 8, width of the ballots-cast counter

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-low reset
ballot_issue  in  1  officer key; level input, rising edge detected internally
poll_close  in  1  level; requests end of poll
vo_switch  in  NUM_CAND  voter push-buttons, raw level
vote_valid  out  1  one-cycle pulse; vote_sel is valid this cycle
vote_sel  out  NUM_CAND  one-hot choice, zero when vote_valid=0
ready_led  out  1  ballot armed, voter may press
pled  out  NUM_CAND  confirmation LED, copy of the chosen switch
invalid  out  1  one-cycle pulse on a rejected press
timeout  out  1  one-cycle pulse when an armed ballot is voided
closed  out  1  poll closed
cast_cnt  out  CNT_W  ballots successfully cast

Behaviour:
- Reset (rst=0 at posedge): state IDLE. All outputs 0. Edge register, timers and close_pending cleared. Reset overrides everything, including mid-ARMED and mid-CONFIRM; a vote in flight is lost and no vote_valid is issued.
- States: IDLE, ARMED, CONFIRM, RELEASE, CLOSED. Encoding is 3-bit binary.
- IDLE:
  - If close_pending or poll_close=1: go to CLOSED.
  - Else, on the ballot_issue rising edge with vo_switch==0: go to ARMED.
  - On the rising edge with vo_switch!=0 (stuck-button guard): pulse invalid and stay in IDLE.
- ARMED:
  - ready_led=1. Timer counts up from 0.
  - vo_switch one-hot: on the next cycle vote_valid=1 and vote_sel=captured value (1-cycle latency from the sampling edge). cast_cnt increments in the same cycle, saturating at all-ones. pled loads the captured value. Go to CONFIRM.
  - vo_switch has more than one bit set: pulse invalid, stay in ARMED, timer continues.
  - vo_switch==0: wait.
  - Further ballot_issue edges are ignored.
- CONFIRM: pled held for exactly CONF_CYC cycles, then cleared. Go to RELEASE.
- RELEASE: wait until vo_switch==0 for one sampled cycle, then go to IDLE. This prevents a held button from voting on the next ballot.
- CLOSED: terminal until reset. ready_led=0. All ballot_issue and vo_switch activity is ignored; no invalid pulses. closed=1.
- poll_close asserted in ARMED, CONFIRM or RELEASE sets close_pending. The current ballot completes normally; CLOSED is entered from IDLE.
- Simultaneous events:
  - A valid press on the same edge that the timeout expires: the vote wins.
  - poll_close together with a ballot_issue edge in IDLE: close wins and no ballot is armed.
- Width rules: one-hot check is vo_switch!=0 and (vo_switch & (vo_switch-1))==0. Timer width is clog2(max(CONF_CYC,TIMEOUT_CYC))+1.

Optional Feature:
BALLOT_TIMEOUT_EN
- Defined: when the ARMED timer reaches TIMEOUT_CYC-1 with no valid press, pulse timeout, void the ballot (cast_cnt unchanged) and go to IDLE.
- Undefined: ARMED waits indefinitely, the timeout output is tied 0, and TIMEOUT_CYC is unused.

Decomposition:
- Package evm_pkg: state enum typedef, NUM_CAND default, NOTA index constant, one-hot check function.
- One natural sub-module, evm_edge_det: registered rising-edge detector used on ballot_issue. Everything else stays in the top.

Test Plan:
- Reset, then ballot_issue edge, then vo_switch=5'b00100 -> ready_led=1; one cycle after the press vote_valid=1 with vote_sel=00100; pled=00100 for 4 cycles; cast_cnt=1.
- Armed, vo_switch=5'b00110 -> invalid pulse, still ARMED; then 5'b10000 -> vote_sel=10000 (NOTA); cast_cnt=1.
- Hold vo_switch=5'b00001 through CONFIRM and issue a new ballot -> stays in RELEASE, no arm, no second vote until the switch is released to 0.
- BALLOT_TIMEOUT_EN defined, armed with no press for 16 cycles -> timeout pulse, back to IDLE, cast_cnt unchanged.
- poll_close pulsed during CONFIRM -> vote counted, closed=1 after RELEASE/IDLE; later ballot_issue and presses produce no outputs.
- rst=0 mid-ARMED while vo_switch=5'b01000 -> no vote_valid; all outputs 0 next cycle; cast_cnt=0.
